eth_rx_frame_parser: RTL and testbench
======================================

# eth_rx_frame_parser

Parametrised Ethernet receive parser, successor to the plain RGMII byte pass-through used around `packet_parser_top`. It consumes the 8-bit RGMII receive byte stream and performs the following steps:
- strips preamble/SFD;
- extracts destination MAC, source MAC, optional 802.1Q tag and ethertype;
- applies a destination-address filter;
- emits the payload as a framed byte stream with the 4-byte FCS removed;
- reports one status pulse per frame.

It sits directly behind the RGMII receive interface and feeds the packet parsing pipeline at line rate; there is no backpressure.

## Interface
Parameters:
- MAC_ADDR, 48'h02_00_00_00_00_01, local unicast address
- PROMISC, 0, 1 = accept every destination address
- ACCEPT_MCAST, 1, 1 = accept multicast (I/G bit of first dst byte set)
- VLAN_EN, 1, 1 = parse 0x8100 tag; 0 = treat 0x8100 as ordinary ethertype
- MIN_FRAME, 64, minimum frame length, dst..FCS inclusive
- MAX_FRAME, 1518, maximum untagged length; tagged limit is MAX_FRAME+4

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-low reset
- rgmii_rx_data  in  8  received byte
- rgmii_rx_valid  in  1  byte qualifier; low for at least 1 cycle between frames
- hdr_valid  out  1  1-cycle pulse; hdr_* fields valid and held until next pulse
- hdr_dst_mac  out  48  first byte received in [47:40]
- hdr_src_mac  out  48  same byte order
- hdr_ethertype  out  16  inner ethertype when tagged
- hdr_vlan_present  out  1  tag parsed
- hdr_vlan_tci  out  16  TCI; 0 when untagged
- pay_data  out  8  payload byte
- pay_valid  out  1  payload qualifier
- pay_sop  out  1  first payload byte
- pay_eop  out  1  last payload byte
- pay_err  out  1  with pay_eop: frame truncated or erroneous
- stat_good, stat_runt, stat_giant, stat_filtered, stat_bad_preamble  out  1 each  1-cycle end-of-frame status pulses, mutually exclusive

## Operation
- Outputs are registered. Reset value of every output is 0. Reset is asynchronous and may occur mid-frame: the state returns to IDLE, and no eop or status pulse is emitted for the aborted frame.
- State machine: IDLE, PRE, DST, SRC, TYPE, VTAG, PAYLOAD, DROP.
- IDLE to PRE: on the first valid byte.
  - The first byte must be 0x55.
  - PRE accepts 1..7 bytes of 0x55, then 0xD5 moves to DST.
  - Any other byte, an 8th 0x55, or a leading 0xD5 goes to DROP and is flagged as a bad preamble.
- DST: 6 bytes. The filter decides on the 6th byte; a miss goes to DROP and is flagged as filtered. Accept when any of the following holds:
  - PROMISC;
  - dst == MAC_ADDR;
  - dst == all-ones;
  - ACCEPT_MCAST and bit 0 of the first byte is set.
- SRC: 6 bytes. TYPE: 2 bytes.
  - If VLAN_EN and the type is 0x8100, go to VTAG: 2 TCI bytes, then 2 inner-type bytes.
  - hdr_valid fires after the final type byte. Filtered frames never assert hdr_valid.
- PAYLOAD: bytes enter a 5-entry shift buffer.
  - When a byte arrives with the buffer full, the oldest entry is emitted with pay_eop=0.
  - pay_sop is set on the first emission of the frame.
- End of frame (valid low while in PAYLOAD):
  - If the buffer holds 5 entries, the oldest is emitted with pay_eop=1; the remaining 4 entries (the FCS) are discarded.
  - If the buffer holds 4 or fewer entries, nothing is emitted.
  - pay_err=1 on that eop if the frame is a runt.
- Length counter: counts dst..FCS bytes and saturates at MAX_FRAME+5.
  - The limit is MAX_FRAME, or MAX_FRAME+4 when hdr_vlan_present.
  - When the count exceeds the limit, the oldest buffered byte is emitted with pay_eop=1, pay_err=1 (only if pay_sop has already been emitted; otherwise nothing is emitted). The buffer is flushed and the state goes to DROP.
- DROP ignores bytes until valid goes low.
- Valid low in DST/SRC/TYPE/VTAG: no payload is emitted; the frame is reported as a runt.
- Status priority: bad_preamble > filtered > giant > runt > good. Exactly one status pulse per frame that reaches DST or fails in PRE.

## Timing
- hdr_valid: 1 cycle after the last type byte is sampled.
- Payload byte k is emitted 1 cycle after byte k+5 is sampled.
- The last payload byte and the status pulse both appear 1 cycle after the first valid-low cycle.
- The giant cut appears 1 cycle after the byte that exceeds the limit is sampled; stat_giant appears 1 cycle after the first valid-low cycle.
- The state is IDLE on the cycle after valid falls. A new frame may start on the next valid-high cycle, so 1 idle cycle between frames is sufficient.
- Throughput: 1 byte/cycle, no stalls.

## Test plan
- 7×0x55, 0xD5, dst=MAC_ADDR, src=0x0A..0F, type 0x0800, 46 payload bytes 0x00..0x2D, 4 FCS -> hdr_valid with matching fields; 46 pay_valid cycles 0x00..0x2D; sop on 0x00; eop on 0x2D with pay_err=0; stat_good.
- Same frame with 0x8100 TCI 0x2064 and inner type 0x86DD -> hdr_vlan_present=1, tci=0x2064, ethertype=0x86DD; stat_good; 1522-byte tagged frame not giant.
- dst=02:00:00:00:00:99 with PROMISC=0 -> no hdr_valid, no pay_valid, stat_filtered. Broadcast dst -> accepted.
- Preamble 0x55,0x54 -> stat_bad_preamble, no outputs. 8×0x55 -> stat_bad_preamble.
- 1600-byte untagged frame -> eop+err 1 cycle after byte 1519 is sampled, no further pay_valid, stat_giant at frame end. 40-byte frame -> eop+err, stat_runt.
- Assert rst mid-payload -> all outputs 0 immediately. Next frame, after a 1-cycle gap, is parsed correctly with stat_good.

Source files
------------

// File: rtl/eth_rx_frame_parser.sv
// Ethernet receive parser: strips preamble/SFD, extracts header fields, filters on
// destination, forwards payload without FCS and raises one status pulse per frame.
module eth_rx_frame_parser #(
  parameter logic [47:0] MAC_ADDR     = 48'h02_00_00_00_00_01,
  parameter bit          PROMISC      = 1'b0,
  parameter bit          ACCEPT_MCAST = 1'b1,
  parameter bit          VLAN_EN      = 1'b1,
  parameter int          MIN_FRAME    = 64,
  parameter int          MAX_FRAME    = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rgmii_rx_data,
  input  logic        rgmii_rx_valid,
  output logic        hdr_valid,
  output logic [47:0] hdr_dst_mac,
  output logic [47:0] hdr_src_mac,
  output logic [15:0] hdr_ethertype,
  output logic        hdr_vlan_present,
  output logic [15:0] hdr_vlan_tci,
  output logic [7:0]  pay_data,
  output logic        pay_valid,
  output logic        pay_sop,
  output logic        pay_eop,
  output logic        pay_err,
  output logic        stat_good,
  output logic        stat_runt,
  output logic        stat_giant,
  output logic        stat_filtered,
  output logic        stat_bad_preamble
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_DST, S_SRC, S_TYPE, S_VTAG, S_PAYLOAD, S_DROP
  } state_t;

  localparam logic [15:0] LIM_UNTAG = 16'(MAX_FRAME);
  localparam logic [15:0] LIM_TAG   = 16'(MAX_FRAME + 4);
  localparam logic [15:0] LEN_SAT   = 16'(MAX_FRAME + 5);
  localparam logic [15:0] MIN_LEN   = 16'(MIN_FRAME);

  state_t      state_q, state_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic [15:0] len_q, len_d;
  logic [47:0] dst_w_q, dst_w_d, src_w_q, src_w_d;
  logic [15:0] type_w_q, type_w_d, tci_w_q, tci_w_d;
  logic        vlan_w_q, vlan_w_d;
  logic [7:0]  buf_q [5];
  logic [7:0]  buf_d [5];
  logic [2:0]  buf_cnt_q, buf_cnt_d;
  logic        sop_done_q, sop_done_d;
  logic        drop_bad_q, drop_bad_d, drop_filt_q, drop_filt_d, drop_giant_q, drop_giant_d;

  logic        hdr_valid_q, hdr_valid_d, hdr_vlan_q, hdr_vlan_d;
  logic [47:0] hdr_dst_q, hdr_dst_d, hdr_src_q, hdr_src_d;
  logic [15:0] hdr_type_q, hdr_type_d, hdr_tci_q, hdr_tci_d;
  logic [7:0]  pay_data_q, pay_data_d;
  logic        pay_valid_q, pay_valid_d, pay_sop_q, pay_sop_d;
  logic        pay_eop_q, pay_eop_d, pay_err_q, pay_err_d;
  logic        st_good_q, st_good_d, st_runt_q, st_runt_d, st_giant_q, st_giant_d;
  logic        st_filt_q, st_filt_d, st_bad_q, st_bad_d;

  logic [15:0] len_inc, limit;
  logic [47:0] dst_full;
  logic [15:0] typ_full;
  logic        dst_hit;

  assign len_inc  = (len_q >= LEN_SAT) ? LEN_SAT : len_q + 16'd1;
  assign limit    = vlan_w_q ? LIM_TAG : LIM_UNTAG;
  assign dst_full = {dst_w_q[39:0], rgmii_rx_data};
  assign typ_full = {type_w_q[7:0], rgmii_rx_data};
  // Multicast test looks at the I/G bit of the first destination byte.
  assign dst_hit  = PROMISC || (dst_full == MAC_ADDR) || (&dst_full) ||
                    (ACCEPT_MCAST && dst_full[40]);

  always_comb begin
    state_d = state_q;  fcnt_d = fcnt_q;  len_d = len_q;
    dst_w_d = dst_w_q;  src_w_d = src_w_q;  type_w_d = type_w_q;
    tci_w_d = tci_w_q;  vlan_w_d = vlan_w_q;
    for (int i = 0; i < 5; i++) buf_d[i] = buf_q[i];
    buf_cnt_d = buf_cnt_q;  sop_done_d = sop_done_q;
    drop_bad_d = drop_bad_q;  drop_filt_d = drop_filt_q;  drop_giant_d = drop_giant_q;
    hdr_valid_d = 1'b0;  hdr_dst_d = hdr_dst_q;  hdr_src_d = hdr_src_q;
    hdr_type_d = hdr_type_q;  hdr_vlan_d = hdr_vlan_q;  hdr_tci_d = hdr_tci_q;
    pay_data_d = pay_data_q;  pay_valid_d = 1'b0;  pay_sop_d = 1'b0;
    pay_eop_d = 1'b0;  pay_err_d = 1'b0;
    st_good_d = 1'b0;  st_runt_d = 1'b0;  st_giant_d = 1'b0;
    st_filt_d = 1'b0;  st_bad_d = 1'b0;

    case (state_q)
      S_IDLE: if (rgmii_rx_valid) begin
        fcnt_d = 3'd1;  len_d = '0;  vlan_w_d = 1'b0;  tci_w_d = '0;
        buf_cnt_d = '0;  sop_done_d = 1'b0;
        drop_bad_d = 1'b0;  drop_filt_d = 1'b0;  drop_giant_d = 1'b0;
        if (rgmii_rx_data == 8'h55) state_d = S_PRE;
        else begin state_d = S_DROP; drop_bad_d = 1'b1; end
      end
      S_PRE: begin
        if (!rgmii_rx_valid) state_d = S_IDLE;
        else if (rgmii_rx_data == 8'hD5) begin state_d = S_DST; fcnt_d = '0; end
        else if (rgmii_rx_data == 8'h55 && fcnt_q < 3'd7) fcnt_d = fcnt_q + 3'd1;
        else begin state_d = S_DROP; drop_bad_d = 1'b1; end
      end
      S_DST, S_SRC, S_TYPE, S_VTAG: begin
        if (!rgmii_rx_valid) begin
          state_d = S_IDLE;
          st_runt_d = 1'b1;
        end else begin
          len_d  = len_inc;
          fcnt_d = fcnt_q + 3'd1;
          if (state_q == S_DST) begin
            dst_w_d = dst_full;
            if (fcnt_q == 3'd5) begin
              fcnt_d = '0;
              if (dst_hit) state_d = S_SRC;
              else begin state_d = S_DROP; drop_filt_d = 1'b1; end
            end
          end else if (state_q == S_SRC) begin
            src_w_d = {src_w_q[39:0], rgmii_rx_data};
            if (fcnt_q == 3'd5) begin state_d = S_TYPE; fcnt_d = '0; end
          end else if (state_q == S_VTAG && fcnt_q < 3'd2) begin
            tci_w_d = {tci_w_q[7:0], rgmii_rx_data};
          end else begin
            type_w_d = typ_full;
            if (state_q == S_TYPE && fcnt_q == 3'd1 && VLAN_EN && typ_full == 16'h8100) begin
              state_d = S_VTAG;  fcnt_d = '0;  vlan_w_d = 1'b1;
            end else if ((state_q == S_TYPE && fcnt_q == 3'd1) ||
                         (state_q == S_VTAG && fcnt_q == 3'd3)) begin
              state_d = S_PAYLOAD;
              hdr_valid_d = 1'b1;  hdr_dst_d = dst_w_q;  hdr_src_d = src_w_q;
              hdr_type_d = typ_full;  hdr_vlan_d = vlan_w_q;  hdr_tci_d = tci_w_q;
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (!rgmii_rx_valid) begin
          state_d = S_IDLE;
          buf_cnt_d = '0;
          if (buf_cnt_q == 3'd5) begin
            pay_valid_d = 1'b1;  pay_data_d = buf_q[0];  pay_sop_d = !sop_done_q;
            pay_eop_d = 1'b1;  pay_err_d = (len_q < MIN_LEN);
          end
          if (len_q < MIN_LEN) st_runt_d = 1'b1;
          else                 st_good_d = 1'b1;
        end else begin
          len_d = len_inc;
          if (len_inc > limit) begin
            // Cut only a stream that has already opened with sop.
            if (sop_done_q && buf_cnt_q == 3'd5) begin
              pay_valid_d = 1'b1;  pay_data_d = buf_q[0];
              pay_eop_d = 1'b1;  pay_err_d = 1'b1;
            end
            buf_cnt_d = '0;  state_d = S_DROP;  drop_giant_d = 1'b1;
          end else if (buf_cnt_q == 3'd5) begin
            pay_valid_d = 1'b1;  pay_data_d = buf_q[0];  pay_sop_d = !sop_done_q;
            sop_done_d = 1'b1;
            for (int i = 0; i < 4; i++) buf_d[i] = buf_q[i+1];
            buf_d[4] = rgmii_rx_data;
          end else begin
            for (int i = 0; i < 5; i++) if (buf_cnt_q == 3'(i)) buf_d[i] = rgmii_rx_data;
            buf_cnt_d = buf_cnt_q + 3'd1;
          end
        end
      end
      S_DROP: if (!rgmii_rx_valid) begin
        state_d = S_IDLE;
        st_bad_d   = drop_bad_q;
        st_filt_d  = !drop_bad_q && drop_filt_q;
        st_giant_d = !drop_bad_q && !drop_filt_q && drop_giant_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;  fcnt_q <= '0;  len_q <= '0;
      dst_w_q <= '0;  src_w_q <= '0;  type_w_q <= '0;  tci_w_q <= '0;  vlan_w_q <= 1'b0;
      for (int i = 0; i < 5; i++) buf_q[i] <= '0;
      buf_cnt_q <= '0;  sop_done_q <= 1'b0;
      drop_bad_q <= 1'b0;  drop_filt_q <= 1'b0;  drop_giant_q <= 1'b0;
      hdr_valid_q <= 1'b0;  hdr_dst_q <= '0;  hdr_src_q <= '0;
      hdr_type_q <= '0;  hdr_vlan_q <= 1'b0;  hdr_tci_q <= '0;
      pay_data_q <= '0;  pay_valid_q <= 1'b0;  pay_sop_q <= 1'b0;
      pay_eop_q <= 1'b0;  pay_err_q <= 1'b0;
      st_good_q <= 1'b0;  st_runt_q <= 1'b0;  st_giant_q <= 1'b0;
      st_filt_q <= 1'b0;  st_bad_q <= 1'b0;
    end else begin
      state_q <= state_d;  fcnt_q <= fcnt_d;  len_q <= len_d;
      dst_w_q <= dst_w_d;  src_w_q <= src_w_d;  type_w_q <= type_w_d;
      tci_w_q <= tci_w_d;  vlan_w_q <= vlan_w_d;
      for (int i = 0; i < 5; i++) buf_q[i] <= buf_d[i];
      buf_cnt_q <= buf_cnt_d;  sop_done_q <= sop_done_d;
      drop_bad_q <= drop_bad_d;  drop_filt_q <= drop_filt_d;  drop_giant_q <= drop_giant_d;
      hdr_valid_q <= hdr_valid_d;  hdr_dst_q <= hdr_dst_d;  hdr_src_q <= hdr_src_d;
      hdr_type_q <= hdr_type_d;  hdr_vlan_q <= hdr_vlan_d;  hdr_tci_q <= hdr_tci_d;
      pay_data_q <= pay_data_d;  pay_valid_q <= pay_valid_d;  pay_sop_q <= pay_sop_d;
      pay_eop_q <= pay_eop_d;  pay_err_q <= pay_err_d;
      st_good_q <= st_good_d;  st_runt_q <= st_runt_d;  st_giant_q <= st_giant_d;
      st_filt_q <= st_filt_d;  st_bad_q <= st_bad_d;
    end
  end

  assign hdr_valid         = hdr_valid_q;
  assign hdr_dst_mac       = hdr_dst_q;
  assign hdr_src_mac       = hdr_src_q;
  assign hdr_ethertype     = hdr_type_q;
  assign hdr_vlan_present  = hdr_vlan_q;
  assign hdr_vlan_tci      = hdr_tci_q;
  assign pay_data          = pay_data_q;
  assign pay_valid         = pay_valid_q;
  assign pay_sop           = pay_sop_q;
  assign pay_eop           = pay_eop_q;
  assign pay_err           = pay_err_q;
  assign stat_good         = st_good_q;
  assign stat_runt         = st_runt_q;
  assign stat_giant        = st_giant_q;
  assign stat_filtered     = st_filt_q;
  assign stat_bad_preamble = st_bad_q;

endmodule

// File: tb/tb_eth_rx_frame_parser.sv
// Directed bench for eth_rx_frame_parser: frames are streamed from a stimulus queue,
// a negedge monitor logs outputs, and per-frame deltas are checked with assertions.
module tb_eth_rx_frame_parser;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        hdr_valid, hdr_vlan_present;
  logic [47:0] hdr_dst_mac, hdr_src_mac;
  logic [15:0] hdr_ethertype, hdr_vlan_tci;
  logic [7:0]  pay_data;
  logic        pay_valid, pay_sop, pay_eop, pay_err;
  logic        stat_good, stat_runt, stat_giant, stat_filtered, stat_bad_preamble;

  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] SRC   = 48'h0A_0B_0C_0D_0E_0F;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

  eth_rx_frame_parser dut (
    .clk(clk), .rst(rst), .rgmii_rx_data(rx_data), .rgmii_rx_valid(rx_valid),
    .hdr_valid(hdr_valid), .hdr_dst_mac(hdr_dst_mac), .hdr_src_mac(hdr_src_mac),
    .hdr_ethertype(hdr_ethertype), .hdr_vlan_present(hdr_vlan_present),
    .hdr_vlan_tci(hdr_vlan_tci), .pay_data(pay_data), .pay_valid(pay_valid),
    .pay_sop(pay_sop), .pay_eop(pay_eop), .pay_err(pay_err),
    .stat_good(stat_good), .stat_runt(stat_runt), .stat_giant(stat_giant),
    .stat_filtered(stat_filtered), .stat_bad_preamble(stat_bad_preamble)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: logs every observable event with the edge count at which it appeared.
  logic [7:0] pay_q[$];
  int pay_cyc[$];
  int hdr_cnt = 0, hdr_cyc = 0, sop_cnt = 0, sop_cyc = 0, eop_cnt = 0, eop_cyc = 0;
  logic [7:0] sop_data = 0, eop_data = 0;
  logic eop_err = 0;
  int n_good = 0, n_runt = 0, n_giant = 0, n_filt = 0, n_bad = 0, stat_cyc = 0, n_multi = 0;
  always @(negedge clk) begin
    if (pay_valid) begin pay_q.push_back(pay_data); pay_cyc.push_back(cyc); end
    if (hdr_valid) begin hdr_cnt++; hdr_cyc = cyc; end
    if (pay_valid && pay_sop) begin sop_cnt++; sop_cyc = cyc; sop_data = pay_data; end
    if (pay_valid && pay_eop) begin eop_cnt++; eop_cyc = cyc; eop_data = pay_data; eop_err = pay_err; end
    if (stat_good) n_good++;
    if (stat_runt) n_runt++;
    if (stat_giant) n_giant++;
    if (stat_filtered) n_filt++;
    if (stat_bad_preamble) n_bad++;
    if (stat_good | stat_runt | stat_giant | stat_filtered | stat_bad_preamble) stat_cyc = cyc;
    if (32'(stat_good) + 32'(stat_runt) + 32'(stat_giant) + 32'(stat_filtered) +
        32'(stat_bad_preamble) > 1) n_multi++;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [8:0] stim[$];
  int edge_q[$];
  int b_pay, b_hdr, b_sop, b_eop, b_good, b_runt, b_giant, b_filt, b_bad;

  task automatic new_test();
    stim.delete(); edge_q.delete();
    b_pay = pay_q.size(); b_hdr = hdr_cnt; b_sop = sop_cnt; b_eop = eop_cnt;
    b_good = n_good; b_runt = n_runt; b_giant = n_giant; b_filt = n_filt; b_bad = n_bad;
  endtask

  task automatic push_b(input logic [7:0] b); stim.push_back({1'b1, b}); endtask
  task automatic push_gap(); stim.push_back(9'h000); endtask
  task automatic push_w16(input logic [15:0] w); push_b(w[15:8]); push_b(w[7:0]); endtask
  task automatic push_mac(input logic [47:0] m);
    for (int i = 0; i < 6; i++) push_b(m[47-8*i -: 8]);
  endtask
  task automatic push_pre(); for (int i = 0; i < 7; i++) push_b(8'h55); push_b(8'hD5); endtask

  // Full frame with preamble, payload start..start+npay-1, 4 FCS bytes and a closing gap.
  task automatic push_frame(input logic [47:0] dst, input bit tag, input logic [15:0] tci,
                            input logic [15:0] et, input logic [7:0] start, input int npay);
    push_pre(); push_mac(dst); push_mac(SRC);
    if (tag) begin push_w16(16'h8100); push_w16(tci); end
    push_w16(et);
    for (int i = 0; i < npay; i++) push_b(start + 8'(i));
    push_w16(16'hDEAD); push_w16(16'hBEEF);
    push_gap();
  endtask

  task automatic send(input int tail);
    for (int i = 0; i < stim.size(); i++) begin
      @(posedge clk); #1;
      {rx_valid, rx_data} = stim[i];
      edge_q.push_back(cyc + 1);
    end
    for (int i = 0; i < tail; i++) begin @(posedge clk); #1; rx_valid = 1'b0; rx_data = 8'h00; end
  endtask

  task automatic chk_pay(input string tag, input int base, input int n, input logic [7:0] start);
    int bad = 0;
    for (int i = 0; i < n; i++)
      if (base + i >= pay_q.size() || pay_q[base+i] !== start + 8'(i)) bad++;
    chk(tag, 64'(bad), 64'd0);
  endtask

  task automatic chk_stats(input string tag, input int g, input int r, input int gi,
                           input int f, input int bp);
    chk({tag, "_good"},   64'(n_good - b_good),   64'(g));
    chk({tag, "_runt"},   64'(n_runt - b_runt),   64'(r));
    chk({tag, "_giant"},  64'(n_giant - b_giant), 64'(gi));
    chk({tag, "_filt"},   64'(n_filt - b_filt),   64'(f));
    chk({tag, "_badpre"}, 64'(n_bad - b_bad),     64'(bp));
  endtask

  initial begin
    int s0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hdr_valid", 64'(hdr_valid), 64'd0);
    chk("rst_hdr_dst", 64'(hdr_dst_mac), 64'd0);
    chk("rst_pay_valid", 64'(pay_valid), 64'd0);
    chk("rst_stats", 64'({stat_good, stat_runt, stat_giant, stat_filtered, stat_bad_preamble}), 64'd0);
    rst = 1'b1;

    // Minimum-size untagged frame to the local address.
    new_test(); s0 = 0;
    push_frame(MAC, 1'b0, 16'h0, 16'h0800, 8'h00, 46);
    send(4);
    chk("f1_hdr_cnt", 64'(hdr_cnt - b_hdr), 64'd1);
    chk("f1_hdr_cyc", 64'(hdr_cyc), 64'(edge_q[s0+21]));
    chk("f1_dst", 64'(hdr_dst_mac), 64'(MAC));
    chk("f1_src", 64'(hdr_src_mac), 64'(SRC));
    chk("f1_type", 64'(hdr_ethertype), 64'h0800);
    chk("f1_vlan", 64'({hdr_vlan_present, hdr_vlan_tci}), 64'd0);
    chk("f1_pay_cnt", 64'(pay_q.size() - b_pay), 64'd46);
    chk_pay("f1_pay_data", b_pay, 46, 8'h00);
    chk("f1_first_pay_cyc", 64'(pay_cyc[b_pay]), 64'(edge_q[s0+27]));
    chk("f1_sop", 64'({32'(sop_cnt - b_sop), 24'd0, sop_data}), 64'({32'd1, 24'd0, 8'h00}));
    chk("f1_eop", 64'({eop_data, eop_err}), 64'({8'h2D, 1'b0}));
    chk("f1_eop_cyc", 64'(eop_cyc), 64'(edge_q[s0+72]));
    chk("f1_stat_cyc", 64'(stat_cyc), 64'(edge_q[s0+72]));
    chk_stats("f1", 1, 0, 0, 0, 0);

    // Back-to-back: untagged then tagged with a single idle cycle between them.
    new_test();
    push_frame(MAC, 1'b0, 16'h0, 16'h0800, 8'h10, 46);
    push_frame(MAC, 1'b1, 16'h2064, 16'h86DD, 8'h80, 46);
    send(4);
    chk("b2b_hdr_cnt", 64'(hdr_cnt - b_hdr), 64'd2);
    chk("f2_vlan", 64'(hdr_vlan_present), 64'd1);
    chk("f2_tci", 64'(hdr_vlan_tci), 64'h2064);
    chk("f2_type", 64'(hdr_ethertype), 64'h86DD);
    chk("b2b_pay_cnt", 64'(pay_q.size() - b_pay), 64'd92);
    chk_pay("b2b_pay_a", b_pay, 46, 8'h10);
    chk_pay("b2b_pay_b", b_pay + 46, 46, 8'h80);
    chk("b2b_eop_cnt", 64'(eop_cnt - b_eop), 64'd2);
    chk_stats("b2b", 2, 0, 0, 0, 0);

    // Maximum tagged frame: 1522 bytes is within the tagged limit.
    new_test();
    push_frame(MAC, 1'b1, 16'h0005, 16'h0800, 8'h00, 1500);
    send(4);
    chk("tmax_pay_cnt", 64'(pay_q.size() - b_pay), 64'd1500);
    chk("tmax_eop", 64'({eop_data, eop_err}), 64'({8'hDB, 1'b0}));
    chk_stats("tmax", 1, 0, 0, 0, 0);

    // Destination miss is dropped silently except for the status pulse.
    new_test();
    push_frame(48'h02_00_00_00_00_99, 1'b0, 16'h0, 16'h0800, 8'h00, 46);
    send(4);
    chk("filt_hdr", 64'(hdr_cnt - b_hdr), 64'd0);
    chk("filt_pay", 64'(pay_q.size() - b_pay), 64'd0);
    chk_stats("filt", 0, 0, 0, 1, 0);

    new_test();
    push_frame(BCAST, 1'b0, 16'h0, 16'h0806, 8'h20, 46);
    send(4);
    chk("bc_hdr_cnt", 64'(hdr_cnt - b_hdr), 64'd1);
    chk("bc_dst", 64'(hdr_dst_mac), 64'(BCAST));
    chk("bc_pay_cnt", 64'(pay_q.size() - b_pay), 64'd46);
    chk_stats("bc", 1, 0, 0, 0, 0);

    // Preamble errors: wrong byte, then an eighth 0x55.
    new_test();
    push_b(8'h55); push_b(8'h54); push_mac(MAC); push_mac(SRC); push_w16(16'h0800);
    for (int i = 0; i < 50; i++) push_b(8'(i));
    push_gap();
    for (int i = 0; i < 8; i++) push_b(8'h55);
    push_b(8'hD5); push_mac(MAC); push_mac(SRC); push_w16(16'h0800);
    for (int i = 0; i < 50; i++) push_b(8'(i));
    push_gap();
    send(4);
    chk("pre_hdr", 64'(hdr_cnt - b_hdr), 64'd0);
    chk("pre_pay", 64'(pay_q.size() - b_pay), 64'd0);
    chk_stats("pre", 0, 0, 0, 0, 2);

    // Giant: 1600 bytes untagged, cut when byte 1519 is sampled.
    new_test(); s0 = 0;
    push_frame(MAC, 1'b0, 16'h0, 16'h0800, 8'h00, 1582);
    send(4);
    chk("giant_pay_cnt", 64'(pay_q.size() - b_pay), 64'd1500);
    chk("giant_eop", 64'({eop_data, eop_err}), 64'({8'hDB, 1'b1}));
    chk("giant_eop_cyc", 64'(eop_cyc), 64'(edge_q[s0+8+1518]));
    chk("giant_stat_cyc", 64'(stat_cyc), 64'(edge_q[s0+8+1600]));
    chk_stats("giant", 0, 0, 1, 0, 0);

    // Runt: 40-byte frame still emits its 22 payload bytes, flagged on eop.
    new_test();
    push_frame(MAC, 1'b0, 16'h0, 16'h0800, 8'h30, 22);
    send(4);
    chk("runt_pay_cnt", 64'(pay_q.size() - b_pay), 64'd22);
    chk_pay("runt_pay_data", b_pay, 22, 8'h30);
    chk("runt_eop", 64'({eop_data, eop_err}), 64'({8'h45, 1'b1}));
    chk_stats("runt", 0, 1, 0, 0, 0);

    // Header-phase truncation is a runt with no payload.
    new_test();
    push_pre(); push_mac(MAC); push_mac(SRC); push_gap();
    send(4);
    chk("hdrcut_pay", 64'(pay_q.size() - b_pay), 64'd0);
    chk_stats("hdrcut", 0, 1, 0, 0, 0);

    // Reset mid-payload, then a clean frame.
    new_test();
    push_pre(); push_mac(MAC); push_mac(SRC); push_w16(16'h0800);
    for (int i = 0; i < 20; i++) push_b(8'(i));
    send(0);
    @(posedge clk); #2;
    rst = 1'b0; rx_valid = 1'b0;
    #1;
    chk("mid_rst_pay_valid", 64'(pay_valid), 64'd0);
    chk("mid_rst_hdr_dst", 64'(hdr_dst_mac), 64'd0);
    chk("mid_rst_ethertype", 64'(hdr_ethertype), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_no_eop", 64'(eop_cnt - b_eop), 64'd0);
    chk_stats("mid_rst", 0, 0, 0, 0, 0);
    new_test();
    push_frame(MAC, 1'b0, 16'h0, 16'h0800, 8'h40, 46);
    send(4);
    chk("post_rst_pay_cnt", 64'(pay_q.size() - b_pay), 64'd46);
    chk_pay("post_rst_pay_data", b_pay, 46, 8'h40);
    chk("post_rst_eop", 64'({eop_data, eop_err}), 64'({8'h6D, 1'b0}));
    chk_stats("post_rst", 1, 0, 0, 0, 0);

    chk("stat_exclusive", 64'(n_multi), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
